axi_txn_limiter_flat: RTL and testbench

//  Flat-port AXI4+ATOP stage directly downstream of the ID-width converter's master port.

---
 rtl/axi_txn_limiter_pkg.sv | 19 +
 rtl/axi_txn_counter.sv | 59 +++++
 rtl/axi_txn_limiter_flat.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_txn_limiter_flat.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_txn_limiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_txn_limiter_pkg
//  Brief    : Shared constants and counter-width helper for the AXI txn limiter
//  Revision : 1.0 - initial release
// ============================================================================
package axi_txn_limiter_pkg;

    // ATOP bit that marks an atomic which also returns an R burst.
    localparam int ATOP_R_RESP = 5;

    function automatic int cnt_width(input int max_wr, input int max_rd);
        int max_v;
        max_v = (max_wr > max_rd) ? max_wr : max_rd;
        return $clog2(max_v + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_txn_counter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_txn_counter
//  Brief    : Saturating occupancy counter, +0/+1/+2 increment and -1 decrement
//  Revision : 1.0 - initial release
// ============================================================================
module axi_txn_counter #(
    parameter int MAX = 8,
    parameter int W   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [1:0]   inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         almost_full_o
);

    logic [W-1:0] r_cnt;
    logic [W:0]   w_sum;
    logic [W-1:0] w_cnt_next;

    always_comb begin
        w_sum      = {1'b0, r_cnt} + (W+1)'(inc_i);
        w_cnt_next = r_cnt;
        // A decrement with nothing to remove is a protocol error; hold at zero.
        if (dec_i && (w_sum == '0)) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = W'(w_sum - (W+1)'(dec_i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt_o         = r_cnt;
    assign full_o        = (r_cnt == W'(MAX));
    assign almost_full_o = (r_cnt == W'(MAX - 1));

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(dec_i && (w_sum == '0)))
                else $error("axi_txn_counter: decrement while empty");
            assert ((w_sum - (W+1)'(dec_i)) <= (W+1)'(MAX) || (dec_i && (w_sum == '0)))
                else $error("axi_txn_counter: count would exceed MAX");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/axi_txn_limiter_flat.sv
`default_nettype none
// ============================================================================
//  Module   : axi_txn_limiter_flat
//  Brief    : Zero-latency AXI4+ATOP pass-through that caps outstanding
//             write and read transactions by gating AW/AR handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_txn_limiter_flat
    import axi_txn_limiter_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MAX_WR_TXNS    = 8,
    parameter int MAX_RD_TXNS    = 8,
    parameter int CNT_W          = cnt_width(MAX_WR_TXNS, MAX_RD_TXNS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // upstream AW
    input  logic [AXI_ID_WIDTH-1:0]     slv_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   slv_aw_addr_i,
    input  logic [7:0]                  slv_aw_len_i,
    input  logic [2:0]                  slv_aw_size_i,
    input  logic [1:0]                  slv_aw_burst_i,
    input  logic                        slv_aw_lock_i,
    input  logic [3:0]                  slv_aw_cache_i,
    input  logic [2:0]                  slv_aw_prot_i,
    input  logic [3:0]                  slv_aw_qos_i,
    input  logic [3:0]                  slv_aw_region_i,
    input  logic [5:0]                  slv_aw_atop_i,
    input  logic [AXI_USER_WIDTH-1:0]   slv_aw_user_i,
    input  logic                        slv_aw_valid_i,
    output logic                        slv_aw_ready_o,
    // upstream W
    input  logic [AXI_DATA_WIDTH-1:0]   slv_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] slv_w_strb_i,
    input  logic                        slv_w_last_i,
    input  logic [AXI_USER_WIDTH-1:0]   slv_w_user_i,
    input  logic                        slv_w_valid_i,
    output logic                        slv_w_ready_o,
    // upstream B
    output logic [AXI_ID_WIDTH-1:0]     slv_b_id_o,
    output logic [1:0]                  slv_b_resp_o,
    output logic [AXI_USER_WIDTH-1:0]   slv_b_user_o,
    output logic                        slv_b_valid_o,
    input  logic                        slv_b_ready_i,
    // upstream AR
    input  logic [AXI_ID_WIDTH-1:0]     slv_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   slv_ar_addr_i,
    input  logic [7:0]                  slv_ar_len_i,
    input  logic [2:0]                  slv_ar_size_i,
    input  logic [1:0]                  slv_ar_burst_i,
    input  logic                        slv_ar_lock_i,
    input  logic [3:0]                  slv_ar_cache_i,
    input  logic [2:0]                  slv_ar_prot_i,
    input  logic [3:0]                  slv_ar_qos_i,
    input  logic [3:0]                  slv_ar_region_i,
    input  logic [AXI_USER_WIDTH-1:0]   slv_ar_user_i,
    input  logic                        slv_ar_valid_i,
    output logic                        slv_ar_ready_o,
    // upstream R
    output logic [AXI_ID_WIDTH-1:0]     slv_r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]   slv_r_data_o,
    output logic [1:0]                  slv_r_resp_o,
    output logic                        slv_r_last_o,
    output logic [AXI_USER_WIDTH-1:0]   slv_r_user_o,
    output logic                        slv_r_valid_o,
    input  logic                        slv_r_ready_i,
    // downstream AW
    output logic [AXI_ID_WIDTH-1:0]     mst_aw_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]   mst_aw_addr_o,
    output logic [7:0]                  mst_aw_len_o,
    output logic [2:0]                  mst_aw_size_o,
    output logic [1:0]                  mst_aw_burst_o,
    output logic                        mst_aw_lock_o,
    output logic [3:0]                  mst_aw_cache_o,
    output logic [2:0]                  mst_aw_prot_o,
    output logic [3:0]                  mst_aw_qos_o,
    output logic [3:0]                  mst_aw_region_o,
    output logic [5:0]                  mst_aw_atop_o,
    output logic [AXI_USER_WIDTH-1:0]   mst_aw_user_o,
    output logic                        mst_aw_valid_o,
    input  logic                        mst_aw_ready_i,
    // downstream W
    output logic [AXI_DATA_WIDTH-1:0]   mst_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb_o,
    output logic                        mst_w_last_o,
    output logic [AXI_USER_WIDTH-1:0]   mst_w_user_o,
    output logic                        mst_w_valid_o,
    input  logic                        mst_w_ready_i,
    // downstream B
    input  logic [AXI_ID_WIDTH-1:0]     mst_b_id_i,
    input  logic [1:0]                  mst_b_resp_i,
    input  logic [AXI_USER_WIDTH-1:0]   mst_b_user_i,
    input  logic                        mst_b_valid_i,
    output logic                        mst_b_ready_o,
    // downstream AR
    output logic [AXI_ID_WIDTH-1:0]     mst_ar_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]   mst_ar_addr_o,
    output logic [7:0]                  mst_ar_len_o,
    output logic [2:0]                  mst_ar_size_o,
    output logic [1:0]                  mst_ar_burst_o,
    output logic                        mst_ar_lock_o,
    output logic [3:0]                  mst_ar_cache_o,
    output logic [2:0]                  mst_ar_prot_o,
    output logic [3:0]                  mst_ar_qos_o,
    output logic [3:0]                  mst_ar_region_o,
    output logic [AXI_USER_WIDTH-1:0]   mst_ar_user_o,
    output logic                        mst_ar_valid_o,
    input  logic                        mst_ar_ready_i,
    // downstream R
    input  logic [AXI_ID_WIDTH-1:0]     mst_r_id_i,
    input  logic [AXI_DATA_WIDTH-1:0]   mst_r_data_i,
    input  logic [1:0]                  mst_r_resp_i,
    input  logic                        mst_r_last_i,
    input  logic [AXI_USER_WIDTH-1:0]   mst_r_user_i,
    input  logic                        mst_r_valid_i,
    output logic                        mst_r_ready_o,
    // status
    output logic [CNT_W-1:0]            wr_outstanding_o,
    output logic [CNT_W-1:0]            rd_outstanding_o,
    output logic                        aw_stall_o,
    output logic                        ar_stall_o
);

    logic       w_wr_full;
    logic       w_wr_almost_full;
    logic       w_rd_full;
    logic       w_rd_almost_full;
    logic       w_aw_rresp;
    logic       w_aw_block;
    logic       w_ar_block;
    logic       w_aw_hs;
    logic       w_ar_hs;
    logic       w_b_hs;
    logic       w_r_last_hs;
    logic [1:0] w_wr_inc;
    logic [1:0] w_rd_inc;

    // Payloads are pure wires in both directions.
    assign mst_aw_id_o     = slv_aw_id_i;
    assign mst_aw_addr_o   = slv_aw_addr_i;
    assign mst_aw_len_o    = slv_aw_len_i;
    assign mst_aw_size_o   = slv_aw_size_i;
    assign mst_aw_burst_o  = slv_aw_burst_i;
    assign mst_aw_lock_o   = slv_aw_lock_i;
    assign mst_aw_cache_o  = slv_aw_cache_i;
    assign mst_aw_prot_o   = slv_aw_prot_i;
    assign mst_aw_qos_o    = slv_aw_qos_i;
    assign mst_aw_region_o = slv_aw_region_i;
    assign mst_aw_atop_o   = slv_aw_atop_i;
    assign mst_aw_user_o   = slv_aw_user_i;

    assign mst_w_data_o    = slv_w_data_i;
    assign mst_w_strb_o    = slv_w_strb_i;
    assign mst_w_last_o    = slv_w_last_i;
    assign mst_w_user_o    = slv_w_user_i;

    assign slv_b_id_o      = mst_b_id_i;
    assign slv_b_resp_o    = mst_b_resp_i;
    assign slv_b_user_o    = mst_b_user_i;

    assign mst_ar_id_o     = slv_ar_id_i;
    assign mst_ar_addr_o   = slv_ar_addr_i;
    assign mst_ar_len_o    = slv_ar_len_i;
    assign mst_ar_size_o   = slv_ar_size_i;
    assign mst_ar_burst_o  = slv_ar_burst_i;
    assign mst_ar_lock_o   = slv_ar_lock_i;
    assign mst_ar_cache_o  = slv_ar_cache_i;
    assign mst_ar_prot_o   = slv_ar_prot_i;
    assign mst_ar_qos_o    = slv_ar_qos_i;
    assign mst_ar_region_o = slv_ar_region_i;
    assign mst_ar_user_o   = slv_ar_user_i;

    assign slv_r_id_o      = mst_r_id_i;
    assign slv_r_data_o    = mst_r_data_i;
    assign slv_r_resp_o    = mst_r_resp_i;
    assign slv_r_last_o    = mst_r_last_i;
    assign slv_r_user_o    = mst_r_user_i;

    // Blocking uses only registered state (plus AW request for the +2 case),
    // so a decrement never reaches a ready in the same cycle.
    assign w_aw_rresp = slv_aw_atop_i[ATOP_R_RESP];
    assign w_aw_block = w_wr_full | (w_aw_rresp & w_rd_full);
    assign w_ar_block = w_rd_full | (w_rd_almost_full & slv_aw_valid_i & w_aw_rresp);

    assign mst_aw_valid_o = ~rst_i & slv_aw_valid_i & ~w_aw_block;
    assign slv_aw_ready_o = ~rst_i & mst_aw_ready_i & ~w_aw_block;
    assign mst_ar_valid_o = ~rst_i & slv_ar_valid_i & ~w_ar_block;
    assign slv_ar_ready_o = ~rst_i & mst_ar_ready_i & ~w_ar_block;

    assign mst_w_valid_o  = ~rst_i & slv_w_valid_i;
    assign slv_w_ready_o  = ~rst_i & mst_w_ready_i;
    assign slv_b_valid_o  = ~rst_i & mst_b_valid_i;
    assign mst_b_ready_o  = ~rst_i & slv_b_ready_i;
    assign slv_r_valid_o  = ~rst_i & mst_r_valid_i;
    assign mst_r_ready_o  = ~rst_i & slv_r_ready_i;

    assign aw_stall_o = ~rst_i & slv_aw_valid_i & w_aw_block;
    assign ar_stall_o = ~rst_i & slv_ar_valid_i & w_ar_block;

    assign w_aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
    assign w_ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
    assign w_b_hs      = slv_b_valid_o & slv_b_ready_i;
    assign w_r_last_hs = slv_r_valid_o & slv_r_ready_i & mst_r_last_i;

    always_comb begin
        w_wr_inc = {1'b0, w_aw_hs};
        w_rd_inc = 2'(w_ar_hs) + 2'(w_aw_hs & w_aw_rresp);
    end

    axi_txn_counter #(
        .MAX (MAX_WR_TXNS),
        .W   (CNT_W)
    ) u_wr_cnt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inc_i         (w_wr_inc),
        .dec_i         (w_b_hs),
        .cnt_o         (wr_outstanding_o),
        .full_o        (w_wr_full),
        .almost_full_o (w_wr_almost_full)
    );

    axi_txn_counter #(
        .MAX (MAX_RD_TXNS),
        .W   (CNT_W)
    ) u_rd_cnt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inc_i         (w_rd_inc),
        .dec_i         (w_r_last_hs),
        .cnt_o         (rd_outstanding_o),
        .full_o        (w_rd_full),
        .almost_full_o (w_rd_almost_full)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (wr_outstanding_o <= CNT_W'(MAX_WR_TXNS))
                else $error("axi_txn_limiter_flat: write count above limit");
            assert (rd_outstanding_o <= CNT_W'(MAX_RD_TXNS))
                else $error("axi_txn_limiter_flat: read count above limit");
            assert (!(w_wr_almost_full && w_wr_full))
                else $error("axi_txn_limiter_flat: inconsistent write flags");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_txn_limiter_flat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_txn_limiter_flat
//  Brief    : Directed and random checks of the AXI transaction limiter
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_txn_limiter_flat;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int UW  = 2;
    localparam int MWR = 2;
    localparam int MRD = 4;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IDW-1:0] slv_aw_id, mst_aw_id, slv_ar_id, mst_ar_id, slv_b_id, mst_b_id, slv_r_id, mst_r_id;
    logic [AW-1:0]  slv_aw_addr, mst_aw_addr, slv_ar_addr, mst_ar_addr;
    logic [7:0]     slv_aw_len, mst_aw_len, slv_ar_len, mst_ar_len;
    logic [2:0]     slv_aw_size, mst_aw_size, slv_ar_size, mst_ar_size;
    logic [1:0]     slv_aw_burst, mst_aw_burst, slv_ar_burst, mst_ar_burst;
    logic           slv_aw_lock, mst_aw_lock, slv_ar_lock, mst_ar_lock;
    logic [3:0]     slv_aw_cache, mst_aw_cache, slv_ar_cache, mst_ar_cache;
    logic [2:0]     slv_aw_prot, mst_aw_prot, slv_ar_prot, mst_ar_prot;
    logic [3:0]     slv_aw_qos, mst_aw_qos, slv_ar_qos, mst_ar_qos;
    logic [3:0]     slv_aw_region, mst_aw_region, slv_ar_region, mst_ar_region;
    logic [5:0]     slv_aw_atop, mst_aw_atop;
    logic [UW-1:0]  slv_aw_user, mst_aw_user, slv_ar_user, mst_ar_user;
    logic           slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
    logic           slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
    logic [DW-1:0]  slv_w_data, mst_w_data, slv_r_data, mst_r_data;
    logic [DW/8-1:0] slv_w_strb, mst_w_strb;
    logic           slv_w_last, mst_w_last, slv_r_last, mst_r_last;
    logic [UW-1:0]  slv_w_user, mst_w_user, slv_b_user, mst_b_user, slv_r_user, mst_r_user;
    logic           slv_w_valid, slv_w_ready, mst_w_valid, mst_w_ready;
    logic [1:0]     slv_b_resp, mst_b_resp, slv_r_resp, mst_r_resp;
    logic           slv_b_valid, slv_b_ready, mst_b_valid, mst_b_ready;
    logic           slv_r_valid, slv_r_ready, mst_r_valid, mst_r_ready;
    logic [CW-1:0]  wr_out, rd_out;
    logic           aw_stall, ar_stall;

    int total = 0;
    int bad   = 0;

    axi_txn_limiter_flat #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
        .MAX_WR_TXNS(MWR), .MAX_RD_TXNS(MRD)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_id_i(slv_aw_id), .slv_aw_addr_i(slv_aw_addr), .slv_aw_len_i(slv_aw_len),
        .slv_aw_size_i(slv_aw_size), .slv_aw_burst_i(slv_aw_burst), .slv_aw_lock_i(slv_aw_lock),
        .slv_aw_cache_i(slv_aw_cache), .slv_aw_prot_i(slv_aw_prot), .slv_aw_qos_i(slv_aw_qos),
        .slv_aw_region_i(slv_aw_region), .slv_aw_atop_i(slv_aw_atop), .slv_aw_user_i(slv_aw_user),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
        .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb), .slv_w_last_i(slv_w_last),
        .slv_w_user_i(slv_w_user), .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready),
        .slv_b_id_o(slv_b_id), .slv_b_resp_o(slv_b_resp), .slv_b_user_o(slv_b_user),
        .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready),
        .slv_ar_id_i(slv_ar_id), .slv_ar_addr_i(slv_ar_addr), .slv_ar_len_i(slv_ar_len),
        .slv_ar_size_i(slv_ar_size), .slv_ar_burst_i(slv_ar_burst), .slv_ar_lock_i(slv_ar_lock),
        .slv_ar_cache_i(slv_ar_cache), .slv_ar_prot_i(slv_ar_prot), .slv_ar_qos_i(slv_ar_qos),
        .slv_ar_region_i(slv_ar_region), .slv_ar_user_i(slv_ar_user),
        .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready),
        .slv_r_id_o(slv_r_id), .slv_r_data_o(slv_r_data), .slv_r_resp_o(slv_r_resp),
        .slv_r_last_o(slv_r_last), .slv_r_user_o(slv_r_user),
        .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready),
        .mst_aw_id_o(mst_aw_id), .mst_aw_addr_o(mst_aw_addr), .mst_aw_len_o(mst_aw_len),
        .mst_aw_size_o(mst_aw_size), .mst_aw_burst_o(mst_aw_burst), .mst_aw_lock_o(mst_aw_lock),
        .mst_aw_cache_o(mst_aw_cache), .mst_aw_prot_o(mst_aw_prot), .mst_aw_qos_o(mst_aw_qos),
        .mst_aw_region_o(mst_aw_region), .mst_aw_atop_o(mst_aw_atop), .mst_aw_user_o(mst_aw_user),
        .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
        .mst_w_data_o(mst_w_data), .mst_w_strb_o(mst_w_strb), .mst_w_last_o(mst_w_last),
        .mst_w_user_o(mst_w_user), .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
        .mst_b_id_i(mst_b_id), .mst_b_resp_i(mst_b_resp), .mst_b_user_i(mst_b_user),
        .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready),
        .mst_ar_id_o(mst_ar_id), .mst_ar_addr_o(mst_ar_addr), .mst_ar_len_o(mst_ar_len),
        .mst_ar_size_o(mst_ar_size), .mst_ar_burst_o(mst_ar_burst), .mst_ar_lock_o(mst_ar_lock),
        .mst_ar_cache_o(mst_ar_cache), .mst_ar_prot_o(mst_ar_prot), .mst_ar_qos_o(mst_ar_qos),
        .mst_ar_region_o(mst_ar_region), .mst_ar_user_o(mst_ar_user),
        .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
        .mst_r_id_i(mst_r_id), .mst_r_data_i(mst_r_data), .mst_r_resp_i(mst_r_resp),
        .mst_r_last_i(mst_r_last), .mst_r_user_i(mst_r_user),
        .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready),
        .wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out),
        .aw_stall_o(aw_stall), .ar_stall_o(ar_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {slv_aw_id, slv_aw_addr, slv_aw_len, slv_aw_size, slv_aw_burst, slv_aw_lock} = '0;
        {slv_aw_cache, slv_aw_prot, slv_aw_qos, slv_aw_region, slv_aw_atop, slv_aw_user} = '0;
        {slv_ar_id, slv_ar_addr, slv_ar_len, slv_ar_size, slv_ar_burst, slv_ar_lock} = '0;
        {slv_ar_cache, slv_ar_prot, slv_ar_qos, slv_ar_region, slv_ar_user} = '0;
        {slv_w_data, slv_w_strb, slv_w_last, slv_w_user} = '0;
        {mst_b_id, mst_b_resp, mst_b_user} = '0;
        {mst_r_id, mst_r_data, mst_r_resp, mst_r_last, mst_r_user} = '0;
        {slv_aw_valid, mst_aw_ready, slv_ar_valid, mst_ar_ready, slv_w_valid, mst_w_ready} = '0;
        {mst_b_valid, slv_b_ready, mst_r_valid, slv_r_ready} = '0;
    endtask

    task automatic chk_gated(input string tag);
        chk({tag, "_mst_aw_valid"}, 64'(mst_aw_valid), 64'd0);
        chk({tag, "_slv_aw_ready"}, 64'(slv_aw_ready), 64'd0);
        chk({tag, "_mst_ar_valid"}, 64'(mst_ar_valid), 64'd0);
        chk({tag, "_slv_ar_ready"}, 64'(slv_ar_ready), 64'd0);
        chk({tag, "_mst_w_valid"},  64'(mst_w_valid),  64'd0);
        chk({tag, "_slv_w_ready"},  64'(slv_w_ready),  64'd0);
        chk({tag, "_slv_b_valid"},  64'(slv_b_valid),  64'd0);
        chk({tag, "_mst_b_ready"},  64'(mst_b_ready),  64'd0);
        chk({tag, "_slv_r_valid"},  64'(slv_r_valid),  64'd0);
        chk({tag, "_mst_r_ready"},  64'(mst_r_ready),  64'd0);
        chk({tag, "_aw_stall"},     64'(aw_stall),     64'd0);
        chk({tag, "_ar_stall"},     64'(ar_stall),     64'd0);
    endtask

    task automatic set_all_traffic();
        {slv_aw_valid, mst_aw_ready, slv_ar_valid, mst_ar_ready, slv_w_valid, mst_w_ready} = '1;
        {mst_b_valid, slv_b_ready, mst_r_valid, slv_r_ready} = '1;
    endtask

    int  mwr, mrd;
    logic e_aw_blk, e_ar_blk, e_aw_hs, e_ar_hs, e_b_hs, e_r_hs, a5;

    initial begin
        // ---- reset state, all handshakes forced low, payload passes ----
        rst = 1'b1;
        clear_inputs();
        set_all_traffic();
        slv_aw_addr = 32'hCAFE_0000;
        repeat (2) @(posedge clk);
        #2;
        chk_gated("rst");
        chk("rst_wr_cnt", 64'(wr_out), 64'd0);
        chk("rst_rd_cnt", 64'(rd_out), 64'd0);
        chk("rst_aw_addr_pass", 64'(mst_aw_addr), 64'hCAFE_0000);
        clear_inputs();
        rst = 1'b0;
        tick();

        // ---- write limit: 3 AWs with MAX_WR=2 ----
        mst_aw_ready = 1'b1;
        slv_aw_valid = 1'b1;
        #1;
        chk("aw1_valid", 64'(mst_aw_valid), 64'd1);
        chk("aw1_ready", 64'(slv_aw_ready), 64'd1);
        tick();
        chk("aw1_cnt", 64'(wr_out), 64'd1);
        chk("aw2_valid", 64'(mst_aw_valid), 64'd1);
        tick();
        chk("aw2_cnt", 64'(wr_out), 64'd2);
        chk("aw3_stall", 64'(aw_stall), 64'd1);
        chk("aw3_valid", 64'(mst_aw_valid), 64'd0);
        chk("aw3_ready", 64'(slv_aw_ready), 64'd0);
        mst_b_valid = 1'b1;
        slv_b_ready = 1'b1;
        #1;
        chk("aw3_full_with_dec", 64'(aw_stall), 64'd1);
        chk("b_pass_valid", 64'(slv_b_valid), 64'd1);
        tick();
        chk("b1_cnt", 64'(wr_out), 64'd1);
        mst_b_valid = 1'b0;
        slv_b_ready = 1'b0;
        #1;
        chk("aw3_accept", 64'(mst_aw_valid), 64'd1);
        chk("aw3_no_stall", 64'(aw_stall), 64'd0);
        tick();
        chk("aw3_cnt", 64'(wr_out), 64'd2);
        slv_aw_valid = 1'b0;

        // ---- simultaneous AW and B at wr_cnt=1 ----
        mst_b_valid = 1'b1;
        slv_b_ready = 1'b1;
        tick();
        chk("b2_cnt", 64'(wr_out), 64'd1);
        slv_aw_valid = 1'b1;
        #1;
        chk("awb_valid", 64'(mst_aw_valid), 64'd1);
        tick();
        chk("awb_cnt", 64'(wr_out), 64'd1);
        slv_aw_valid = 1'b0;
        tick();
        chk("b3_cnt", 64'(wr_out), 64'd0);
        mst_b_valid = 1'b0;
        slv_b_ready = 1'b0;

        // ---- read limit: 4 ARs then a 5th ----
        mst_ar_ready = 1'b1;
        slv_ar_valid = 1'b1;
        slv_ar_len   = 8'd3;
        repeat (4) tick();
        chk("ar4_cnt", 64'(rd_out), 64'd4);
        chk("ar5_stall", 64'(ar_stall), 64'd1);
        chk("ar5_valid", 64'(mst_ar_valid), 64'd0);
        chk("ar5_ready", 64'(slv_ar_ready), 64'd0);
        mst_r_valid = 1'b1;
        slv_r_ready = 1'b1;
        mst_r_last  = 1'b0;
        mst_r_data  = 32'h1234_5678;
        #1;
        chk("r_data_pass", 64'(slv_r_data), 64'h1234_5678);
        repeat (3) tick();
        chk("r_nonlast_cnt", 64'(rd_out), 64'd4);
        mst_r_last = 1'b1;
        #1;
        chk("ar5_full_with_dec", 64'(ar_stall), 64'd1);
        tick();
        chk("rlast_cnt", 64'(rd_out), 64'd3);
        mst_r_valid = 1'b0;
        #1;
        chk("ar5_accept", 64'(mst_ar_valid), 64'd1);
        tick();
        chk("ar5_cnt", 64'(rd_out), 64'd4);
        slv_ar_valid = 1'b0;

        // ---- R-ATOP AW and AR together at rd_cnt=MAX-1 ----
        mst_r_valid = 1'b1;
        tick();
        chk("rlast2_cnt", 64'(rd_out), 64'd3);
        mst_r_valid  = 1'b0;
        slv_aw_valid = 1'b1;
        slv_aw_atop  = 6'h20;
        mst_aw_ready = 1'b1;
        slv_ar_valid = 1'b1;
        #1;
        chk("atop_aw_valid", 64'(mst_aw_valid), 64'd1);
        chk("atop_ar_valid", 64'(mst_ar_valid), 64'd0);
        chk("atop_ar_stall", 64'(ar_stall), 64'd1);
        chk("atop_aw_stall", 64'(aw_stall), 64'd0);
        tick();
        chk("atop_rd_cnt", 64'(rd_out), 64'd4);
        chk("atop_wr_cnt", 64'(wr_out), 64'd1);
        slv_ar_valid = 1'b0;
        #1;
        chk("atop_rdfull_stall", 64'(aw_stall), 64'd1);
        chk("atop_rdfull_valid", 64'(mst_aw_valid), 64'd0);
        slv_aw_atop = 6'h10;
        #1;
        chk("atop_nor_valid", 64'(mst_aw_valid), 64'd1);
        tick();
        chk("atop_nor_wr_cnt", 64'(wr_out), 64'd2);
        chk("atop_nor_rd_cnt", 64'(rd_out), 64'd4);
        slv_aw_valid = 1'b0;
        slv_aw_atop  = 6'h00;

        // ---- reset mid-traffic at wr=2, rd=3 ----
        mst_r_valid = 1'b1;
        tick();
        chk("pre_rst_wr", 64'(wr_out), 64'd2);
        chk("pre_rst_rd", 64'(rd_out), 64'd3);
        set_all_traffic();
        rst = 1'b1;
        #1;
        chk_gated("mid_rst");
        tick();
        chk("mid_rst_wr", 64'(wr_out), 64'd0);
        chk("mid_rst_rd", 64'(rd_out), 64'd0);
        chk("mid_rst_aw_valid", 64'(mst_aw_valid), 64'd0);
        clear_inputs();
        rst = 1'b0;
        tick();

        // ---- random traffic against a reference occupancy model ----
        mwr = 0;
        mrd = 0;
        for (int i = 0; i < 400; i++) begin
            slv_aw_valid = 1'($urandom_range(0, 1));
            slv_aw_atop  = ($urandom_range(0, 3) == 0) ? 6'h20 : 6'($urandom_range(0, 31));
            slv_aw_addr  = $urandom;
            mst_aw_ready = 1'($urandom_range(0, 1));
            slv_ar_valid = 1'($urandom_range(0, 1));
            mst_ar_ready = 1'($urandom_range(0, 1));
            mst_b_valid  = (mwr > 0) && ($urandom_range(0, 2) == 0);
            slv_b_ready  = 1'($urandom_range(0, 1));
            mst_r_valid  = (mrd > 0) && ($urandom_range(0, 1) == 0);
            mst_r_last   = 1'($urandom_range(0, 1));
            slv_r_ready  = 1'($urandom_range(0, 1));
            slv_w_valid  = 1'($urandom_range(0, 1));
            slv_w_data   = $urandom;
            mst_r_data   = $urandom;
            #1;
            a5       = slv_aw_atop[5];
            e_aw_blk = (mwr == MWR) || (a5 && mrd == MRD);
            e_ar_blk = (mrd == MRD) || (mrd == MRD - 1 && slv_aw_valid && a5);
            chk("rnd_aw_valid", 64'(mst_aw_valid), 64'(slv_aw_valid & ~e_aw_blk));
            chk("rnd_ar_valid", 64'(mst_ar_valid), 64'(slv_ar_valid & ~e_ar_blk));
            chk("rnd_aw_stall", 64'(aw_stall), 64'(slv_aw_valid & e_aw_blk));
            chk("rnd_w_data", 64'(mst_w_data), 64'(slv_w_data));
            chk("rnd_r_data", 64'(slv_r_data), 64'(mst_r_data));
            chk("rnd_aw_addr", 64'(mst_aw_addr), 64'(slv_aw_addr));
            e_aw_hs = slv_aw_valid & ~e_aw_blk & mst_aw_ready;
            e_ar_hs = slv_ar_valid & ~e_ar_blk & mst_ar_ready;
            e_b_hs  = mst_b_valid & slv_b_ready;
            e_r_hs  = mst_r_valid & slv_r_ready & mst_r_last;
            tick();
            mwr = mwr + int'(e_aw_hs) - int'(e_b_hs);
            mrd = mrd + int'(e_ar_hs) + int'(e_aw_hs & a5) - int'(e_r_hs);
            chk("rnd_wr_cnt", 64'(wr_out), 64'(mwr));
            chk("rnd_rd_cnt", 64'(rd_out), 64'(mrd));
        end
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
